// File: rtl/memread_pkg.sv
// Shared types and constants for the memread block reader.
package memread_pkg;

   // Transfer sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Default buffer depth in 32-bit words.
   localparam int MAX_WORDS_DEF = 8;

   // Slave register map (word offsets).
   localparam logic [3:0] REG_CTRL     = 4'd0;
   localparam logic [3:0] REG_SRC      = 4'd1;
   localparam logic [3:0] REG_COUNT    = 4'd2;
   localparam logic [3:0] REG_SUM      = 4'd3;
   localparam logic [3:0] REG_BUF_BASE = 4'd8;

endpackage

// File: rtl/memread.sv
// CPU-programmable block reader: the CPU sets SRC and COUNT, then writes CTRL.
// The start write is held off with waitrequest while the block issues
// pipelined Avalon-MM reads, fills a small buffer and accumulates a sum.
//
// Handshakes: a slave access completes on the clock edge where
// slave_waitrequest is low; a master read is accepted on the edge where
// master_read is high and master_waitrequest is low; returned data is
// consumed on any edge where master_readdatavalid is high (no back-pressure).
module memread
   import memread_pkg::*;
#(
   parameter int MAX_WORDS = MAX_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   output logic [31:0] slave_readdata,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   input  logic        master_waitrequest,
   output logic [31:0] master_address,
   output logic        master_read,
   input  logic [31:0] master_readdata,
   input  logic        master_readdatavalid,
   output logic        master_write,
   output logic [31:0] master_writedata,
   output state_e      dbg_state_o
);

   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   state_e         state_q, state_d;
   logic [31:0]    src_q, src_d;
   logic [CW-1:0]  count_q, count_d;
   logic [31:0]    sum_q, sum_d;
   logic [31:0]    ptr_q, ptr_d;
   logic [CW-1:0]  issued_q, issued_d;
   logic [CW-1:0]  recv_q, recv_d;
   logic [31:0]    buf_q [MAX_WORDS];
   logic [31:0]    buf_d [MAX_WORDS];
   logic           start;
   logic           unused_read;

   // Readdata is a pure mux of the address, so the read strobe carries no information.
   assign unused_read = slave_read;

   assign start            = slave_write && (slave_address == REG_CTRL);
   assign master_address   = ptr_q;
   assign master_write     = 1'b0;
   assign master_writedata = 32'd0;
   assign dbg_state_o      = state_q;

   // Next-state logic: sequencer, counters, buffer fill and register writes.
   always_comb begin
      state_d           = state_q;
      src_d             = src_q;
      count_d           = count_q;
      sum_d             = sum_q;
      ptr_d             = ptr_q;
      issued_d          = issued_q;
      recv_d            = recv_q;
      buf_d             = buf_q;
      slave_waitrequest = 1'b0;
      master_read       = 1'b0;

      // Returns are only meaningful while a transfer is in flight; the
      // recv<count guard keeps stray pulses from indexing past the buffer.
      if ((state_q == ISSUE || state_q == DRAIN) && master_readdatavalid && (recv_q < count_q)) begin
         buf_d[recv_q[IW-1:0]] = master_readdata;
         sum_d                 = sum_q + master_readdata;
         recv_d                = recv_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               slave_waitrequest = 1'b1;
               issued_d          = '0;
               recv_d            = '0;
               sum_d             = '0;
               ptr_d             = src_q;
               state_d           = (count_q == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            slave_waitrequest = 1'b1;
            master_read       = 1'b1;
            if (!master_waitrequest) begin
               issued_d = issued_q + CW'(1);
               ptr_d    = ptr_q + 32'd4;
               if (issued_d == count_q) begin
                  state_d = (recv_d == count_q) ? DONE : DRAIN;
               end
            end
         end
         DRAIN: begin
            slave_waitrequest = 1'b1;
            if (recv_d == count_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // waitrequest low here lets the held start write retire once.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (slave_write && !slave_waitrequest) begin
         if (slave_address == REG_SRC) begin
            src_d = {slave_writedata[31:2], 2'b00};
         end else if (slave_address == REG_COUNT) begin
            if (slave_writedata > 32'(MAX_WORDS)) begin
               count_d = CW'(MAX_WORDS);
            end else begin
               count_d = slave_writedata[CW-1:0];
            end
         end
      end
   end

   // Slave read mux over the register map.
   always_comb begin
      slave_readdata = 32'd0;
      if (slave_address[3]) begin
         for (int i = 0; i < MAX_WORDS; i++) begin
            if (slave_address[2:0] == 3'(i)) begin
               slave_readdata = buf_q[i];
            end
         end
      end else begin
         case (slave_address)
            REG_CTRL:  slave_readdata = {31'd0, (state_q != IDLE)};
            REG_SRC:   slave_readdata = src_q;
            REG_COUNT: slave_readdata = 32'(count_q);
            REG_SUM:   slave_readdata = sum_q;
            default:   slave_readdata = 32'd0;
         endcase
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         src_q    <= '0;
         count_q  <= '0;
         sum_q    <= '0;
         ptr_q    <= '0;
         issued_q <= '0;
         recv_q   <= '0;
         for (int i = 0; i < MAX_WORDS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         count_q  <= count_d;
         sum_q    <= sum_d;
         ptr_q    <= ptr_d;
         issued_q <= issued_d;
         recv_q   <= recv_d;
         for (int i = 0; i < MAX_WORDS; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

endmodule
